// File: rtl/vga_sync_receiver.sv
// Receiver for the 1-bit-per-colour VGA link: synchronises the pins, measures line/frame
// timing, locks onto stable timing and emits an (x, y, rgb) pixel stream while locked.
module vga_sync_receiver #(
    parameter int unsigned H_START     = 144,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_START     = 35,
    parameter int unsigned V_ACTIVE    = 480,
    parameter bit          SYNC_NEG    = 1'b1,
    parameter int unsigned LINE_TOL    = 2,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned CW          = 12
) (
    input  logic          iCLK,
    input  logic          iRESETn,
    input  logic          iHSYNC,
    input  logic          iVSYNC,
    input  logic [2:0]    iRGB,
    output logic          oPIX_VALID,
    output logic [CW-1:0] oPIX_X,
    output logic [CW-1:0] oPIX_Y,
    output logic [2:0]    oPIX_RGB,
    output logic          oFRAME_START,
    output logic          oLOCKED,
    output logic          oERR,
    output logic [CW-1:0] oLINE_LEN,
    output logic [CW-1:0] oFRAME_LINES
);
    localparam int unsigned   GW        = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] H_LO      = CW'(H_START);
    localparam logic [CW-1:0] H_HI      = CW'(H_START + H_ACTIVE);
    localparam logic [CW-1:0] V_LO      = CW'(V_START);
    localparam logic [CW-1:0] V_HI      = CW'(V_START + V_ACTIVE);
    localparam logic [CW-1:0] TOL       = CW'(LINE_TOL);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} rxState_e;

    logic          hsMeta, hsSync, hsPrev;
    logic          vsMeta, vsSync, vsPrev;
    logic [2:0]    rgbMeta, rgbSync, rgbDly;
    logic          hsEdgeC, vsEdgeC;
    logic [CW-1:0] hcnt, vcnt;
    logic [CW-1:0] lineLenC, frameLinesC, lenDiffC;
    logic          lenOkC, hcntSatC, vcntSatC;
    rxState_e      state, stateNext;
    logic [GW-1:0] goodCnt, goodNext;
    logic [CW-1:0] refLen, refLenNext;
    logic          refValid, refValidNext;
    logic          linesOk, linesOkNext;
    logic          errC, pixValidC, frameStartC;

    // Two-flop synchronisers; rgbDly keeps RGB aligned with hcnt, which trails the pins by 3 cycles
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            hsMeta  <= 1'b0;
            hsSync  <= 1'b0;
            hsPrev  <= 1'b0;
            vsMeta  <= 1'b0;
            vsSync  <= 1'b0;
            vsPrev  <= 1'b0;
            rgbMeta <= 3'b000;
            rgbSync <= 3'b000;
            rgbDly  <= 3'b000;
        end else begin
            hsMeta  <= iHSYNC;
            hsSync  <= hsMeta;
            hsPrev  <= hsSync;
            vsMeta  <= iVSYNC;
            vsSync  <= vsMeta;
            vsPrev  <= vsSync;
            rgbMeta <= iRGB;
            rgbSync <= rgbMeta;
            rgbDly  <= rgbSync;
        end
    end

    // Edges use the raw previous level so the cleared flops never fake an edge after reset
    assign hsEdgeC = SYNC_NEG ? (hsPrev & ~hsSync) : (~hsPrev & hsSync);
    assign vsEdgeC = SYNC_NEG ? (vsPrev & ~vsSync) : (~vsPrev & vsSync);

    assign hcntSatC    = (hcnt == CNT_MAX);
    assign vcntSatC    = (vcnt == CNT_MAX);
    assign lineLenC    = hcntSatC ? CNT_MAX : hcnt + CW'(1);
    assign frameLinesC = vcntSatC ? CNT_MAX : vcnt + CW'(1);
    assign lenDiffC    = (lineLenC >= refLen) ? lineLenC - refLen : refLen - lineLenC;
    assign lenOkC      = (lenDiffC <= TOL);

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            hcnt         <= '0;
            vcnt         <= '0;
            oLINE_LEN    <= '0;
            oFRAME_LINES <= '0;
        end else begin
            if (hsEdgeC) begin
                hcnt      <= '0;
                oLINE_LEN <= lineLenC;
            end else if (!hcntSatC) begin
                hcnt <= hcnt + CW'(1);
            end
            if (vsEdgeC) begin
                vcnt         <= '0;
                oFRAME_LINES <= frameLinesC;
            end else if (hsEdgeC && !vcntSatC) begin
                vcnt <= vcnt + CW'(1);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state    <= SEARCH;
            goodCnt  <= '0;
            refLen   <= '0;
            refValid <= 1'b0;
            linesOk  <= 1'b0;
        end else begin
            state    <= stateNext;
            goodCnt  <= goodNext;
            refLen   <= refLenNext;
            refValid <= refValidNext;
            linesOk  <= linesOkNext;
        end
    end

    // Lock state machine; vs_e wins over a coincident hs_e while measuring
    always_comb begin
        stateNext    = state;
        goodNext     = goodCnt;
        refLenNext   = refLen;
        refValidNext = refValid;
        linesOkNext  = linesOk;
        errC         = 1'b0;
        case (state)
            SEARCH: begin
                goodNext = '0;
                if (vsEdgeC) begin
                    stateNext    = MEASURE;
                    refValidNext = 1'b0;
                    linesOkNext  = 1'b1;
                end
            end
            MEASURE: begin
                if (vsEdgeC) begin
                    refValidNext = 1'b0;
                    linesOkNext  = 1'b1;
                    if (linesOk && (vcnt >= V_HI)) begin
                        if (goodCnt == GOOD_LAST) begin
                            stateNext = LOCKED;
                            goodNext  = '0;
                        end else begin
                            goodNext = goodCnt + GW'(1);
                        end
                    end else begin
                        goodNext = '0;
                    end
                end else if (hsEdgeC) begin
                    if (!refValid) begin
                        refLenNext   = lineLenC;
                        refValidNext = 1'b1;
                    end else if (!lenOkC) begin
                        linesOkNext = 1'b0;
                    end
                end
            end
            LOCKED: begin
                if ((hsEdgeC && !lenOkC) || hcntSatC || vcntSatC || (vsEdgeC && (vcnt < V_HI))) begin
                    errC      = 1'b1;
                    stateNext = SEARCH;
                    goodNext  = '0;
                end
            end
            default: stateNext = SEARCH;
        endcase
    end

    assign pixValidC   = (state == LOCKED) && (hcnt >= H_LO) && (hcnt < H_HI) &&
                         (vcnt >= V_LO) && (vcnt < V_HI);
    assign frameStartC = pixValidC && (hcnt == H_LO) && (vcnt == V_LO);

    // Registered pixel/status outputs; X/Y/RGB hold between valid pixels
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            oPIX_VALID   <= 1'b0;
            oPIX_X       <= '0;
            oPIX_Y       <= '0;
            oPIX_RGB     <= 3'b000;
            oFRAME_START <= 1'b0;
            oLOCKED      <= 1'b0;
            oERR         <= 1'b0;
        end else begin
            oPIX_VALID   <= pixValidC;
            oFRAME_START <= frameStartC;
            oLOCKED      <= (stateNext == LOCKED);
            oERR         <= errC;
            if (pixValidC) begin
                oPIX_X   <= hcnt - H_LO;
                oPIX_Y   <= vcnt - V_LO;
                oPIX_RGB <= rgbDly;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down raster (64x16 total, 40x10 active); one
// active-low instance and one active-high instance fed with inverted sync pins.
module tb_vga_sync_receiver;
    localparam int unsigned CW = 12;
    localparam int HS = 20, HA = 40, VS = 3, VA = 10, HTOT = 64, VTOT = 16, HPW = 8, VPW = 2;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [2:0]    rgb;
        logic          fs;
    } pix_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic          hsPin, vsPin;
    logic [2:0]    rgbPin;
    logic          aValid, aFs, aLocked, aErr, bValid, bFs, bLocked, bErr;
    logic [CW-1:0] aX, aY, aLineLen, aFrameLines, bX, bY, bLineLen, bFrameLines;
    logic [2:0]    aRgb, bRgb;

    always #5 clk = ~clk;

    vga_sync_receiver #(.H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .SYNC_NEG(1'b1),
                        .LINE_TOL(2), .LOCK_FRAMES(2), .CW(CW)) dutA (
        .iCLK(clk), .iRESETn(rstN), .iHSYNC(hsPin), .iVSYNC(vsPin), .iRGB(rgbPin),
        .oPIX_VALID(aValid), .oPIX_X(aX), .oPIX_Y(aY), .oPIX_RGB(aRgb), .oFRAME_START(aFs),
        .oLOCKED(aLocked), .oERR(aErr), .oLINE_LEN(aLineLen), .oFRAME_LINES(aFrameLines));

    vga_sync_receiver #(.H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .SYNC_NEG(1'b0),
                        .LINE_TOL(2), .LOCK_FRAMES(2), .CW(CW)) dutB (
        .iCLK(clk), .iRESETn(rstN), .iHSYNC(~hsPin), .iVSYNC(~vsPin), .iRGB(rgbPin),
        .oPIX_VALID(bValid), .oPIX_X(bX), .oPIX_Y(bY), .oPIX_RGB(bRgb), .oFRAME_START(bFs),
        .oLOCKED(bLocked), .oERR(bErr), .oLINE_LEN(bLineLen), .oFRAME_LINES(bFrameLines));

    pix_t qA[$];
    pix_t qB[$];
    int checks = 0, errors = 0;
    int aPix = 0, bPix = 0, aFsCnt = 0, bFsCnt = 0, aErrs = 0, bErrs = 0, expErrs = 0;
    logic [CW-1:0] aLastX = '0, aLastY = '0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid pixel, counts pulses
    always @(posedge clk) begin
        #1;
        if (aErr) aErrs++;
        if (bErr) bErrs++;
        if (aFs) aFsCnt++;
        if (bFs) bFsCnt++;
        if (aValid) begin
            aPix++;
            aLastX = aX;
            aLastY = aY;
            chk("a_pix_expected", longint'(qA.size() > 0), 1);
            if (qA.size() > 0) chk("a_pix", longint'({aX, aY, aRgb, aFs}), longint'(qA.pop_front()));
        end
        if (bValid) begin
            bPix++;
            chk("b_pix_expected", longint'(qB.size() > 0), 1);
            if (qB.size() > 0) chk("b_pix", longint'({bX, bY, bRgb, bFs}), longint'(qB.pop_front()));
        end
    end

    // Pins are driven active-low; dutB sees them inverted
    task automatic drive(input bit hs, input bit vs, input logic [2:0] rgb);
        @(negedge clk);
        hsPin  = ~hs;
        vsPin  = ~vs;
        rgbPin = rgb;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 3'd0);
    endtask

    task automatic sendLine(input int len, input bit vsAct, input int line, input bit emit);
        for (int c = 0; c < len; c++) begin
            logic [2:0] rgb;
            bit act;
            int x;
            pix_t e;
            x   = c - HS;
            act = (c >= HS) && (c < HS + HA) && (line >= VS) && (line < VS + VA);
            rgb = act ? 3'(x) : 3'($urandom_range(0, 7));
            if (act && emit) begin
                e.x   = CW'(x);
                e.y   = CW'(line - VS);
                e.rgb = 3'(x);
                e.fs  = (x == 0) && (line == VS);
                qA.push_back(e);
                qB.push_back(e);
            end
            drive(c < HPW, vsAct, rgb);
        end
    endtask

    task automatic sendFrame(input int first, input int last, input int emitUpTo,
                             input int badLine, input int badLen);
        for (int l = first; l <= last; l++)
            sendLine((l == badLine) ? badLen : HTOT, l < VPW, l, l <= emitUpTo);
    endtask

    // Two silent frames, then the locking frame must come out complete
    task automatic lockAndCheck(input string tag);
        int pa, pb, fa, fb;
        sendFrame(0, VTOT - 1, -1, -1, 0);
        sendFrame(0, VTOT - 1, -1, -1, 0);
        chk({tag, "_prelock_a"}, aLocked, 0);
        chk({tag, "_prelock_b"}, bLocked, 0);
        pa = aPix; pb = bPix; fa = aFsCnt; fb = bFsCnt;
        sendFrame(0, VTOT - 1, VTOT - 1, -1, 0);
        chk({tag, "_locked_a"}, aLocked, 1);
        chk({tag, "_locked_b"}, bLocked, 1);
        chk({tag, "_pixcount_a"}, aPix - pa, HA * VA);
        chk({tag, "_pixcount_b"}, bPix - pb, HA * VA);
        chk({tag, "_fs_a"}, aFsCnt - fa, 1);
        chk({tag, "_fs_b"}, bFsCnt - fb, 1);
        chk({tag, "_queue_left"}, qA.size() + qB.size(), 0);
        chk({tag, "_last_x"}, aLastX, HA - 1);
        chk({tag, "_last_y"}, aLastY, VA - 1);
        chk({tag, "_line_len_a"}, aLineLen, HTOT);
        chk({tag, "_line_len_b"}, bLineLen, HTOT);
        chk({tag, "_frame_lines_a"}, aFrameLines, VTOT);
        chk({tag, "_frame_lines_b"}, bFrameLines, VTOT);
        chk({tag, "_errs_a"}, aErrs, expErrs);
        chk({tag, "_errs_b"}, bErrs, expErrs);
    endtask

    initial begin
        int pa;
        rstN   = 1'b0;
        hsPin  = 1'b1;
        vsPin  = 1'b1;
        rgbPin = 3'd0;
        idle(4);
        chk("reset_a_outputs", longint'({aValid, aX, aY, aRgb, aFs, aLocked, aErr, aLineLen, aFrameLines}), 0);
        chk("reset_b_outputs", longint'({bValid, bX, bY, bRgb, bFs, bLocked, bErr, bLineLen, bFrameLines}), 0);
        rstN = 1'b1;
        idle(6);
        lockAndCheck("lock");

        // One line slightly long: within tolerance
        pa = aPix;
        sendFrame(0, VTOT - 1, VTOT - 1, 5, HTOT + 1);
        chk("tol_ok_pixcount", aPix - pa, HA * VA);
        chk("tol_ok_locked_a", aLocked, 1);
        chk("tol_ok_locked_b", bLocked, 1);
        chk("tol_ok_errs_a", aErrs, expErrs);
        chk("tol_ok_errs_b", bErrs, expErrs);

        // One line far too long: error after line 5, pixels only up to it
        sendFrame(0, VTOT - 1, 5, 5, HTOT + 10);
        expErrs++;
        chk("tol_bad_errs_a", aErrs, expErrs);
        chk("tol_bad_errs_b", bErrs, expErrs);
        chk("tol_bad_locked_a", aLocked, 0);
        chk("tol_bad_locked_b", bLocked, 0);
        chk("tol_bad_queue_left", qA.size() + qB.size(), 0);
        lockAndCheck("relock_tol");

        // HSYNC missing: hcnt timeout
        idle(4200);
        expErrs++;
        chk("timeout_errs_a", aErrs, expErrs);
        chk("timeout_errs_b", bErrs, expErrs);
        chk("timeout_locked_a", aLocked, 0);
        chk("timeout_locked_b", bLocked, 0);
        lockAndCheck("relock_timeout");

        // Reset in the middle of a locked frame
        sendFrame(0, 4, 4, -1, 0);
        chk("pre_reset_locked", aLocked, 1);
        chk("pre_reset_queue_left", qA.size() + qB.size(), 0);
        rstN = 1'b0;
        #1;
        chk("midreset_a_outputs", longint'({aValid, aX, aY, aRgb, aFs, aLocked, aErr, aLineLen, aFrameLines}), 0);
        chk("midreset_b_outputs", longint'({bValid, bX, bY, bRgb, bFs, bLocked, bErr, bLineLen, bFrameLines}), 0);
        idle(3);
        rstN = 1'b1;
        sendFrame(5, VTOT - 1, -1, -1, 0);
        lockAndCheck("relock_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
